// File: rtl/button_input_unit_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared types and constants for the pushbutton front end:
//   btn_state_t : per-channel debounce / auto-repeat FSM state
//   DEF_*       : default timing constants (100 MHz system clock)
//   clog2       : ceiling log2 for constant sizing
//   code_width  : event-code width, never narrower than one bit
// -----------------------------------------------------------------------------
package button_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    HELD       = 3'd2,
    RPT        = 3'd3,
    DB_RELEASE = 3'd4
  } btn_state_t;

  localparam int DEF_N_CH       = 5;
  localparam int DEF_DB_LIMIT   = 1000000;   // 10 ms
  localparam int DEF_RPT_EN     = 1;
  localparam int DEF_RPT_DELAY  = 50000000;  // 500 ms
  localparam int DEF_RPT_PERIOD = 10000000;  // 100 ms
  localparam int DEF_CNT_W      = 26;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // A single-channel build still needs a one-bit code field.
  function automatic int code_width(input int n_ch);
    return (clog2(n_ch) < 1) ? 1 : clog2(n_ch);
  endfunction

endpackage

// File: rtl/button_input_unit_if.sv
// -----------------------------------------------------------------------------
// button_input_unit_if
// Merged button event stream towards the game-control FSM.
//   evt_valid    : event presented
//   evt_ready    : consumer accepts the presented event
//   evt_code     : channel index of the event
//   evt_repeat   : 0 = initial press, 1 = auto-repeat
//   evt_overflow : per-channel sticky "event lost" flags
// master = button_input_unit, slave = event consumer.
// -----------------------------------------------------------------------------
interface button_input_unit_if
  import button_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int CODE_W = code_width(DEF_N_CH)
);

  logic              evt_valid;
  logic              evt_ready;
  logic [CODE_W-1:0] evt_code;
  logic              evt_repeat;
  logic [N_CH-1:0]   evt_overflow;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_repeat,
    output evt_overflow,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_repeat,
    input  evt_overflow,
    output evt_ready
  );

endinterface

// File: rtl/button_input_unit_channel_fsm.sv
// -----------------------------------------------------------------------------
// button_channel_fsm
// One pushbutton channel: 2-flop synchroniser, debounce counter and
// auto-repeat timer.
//   sys_clk    : system clock
//   Reset      : asynchronous, active-high
//   pb_i       : raw asynchronous button level, 1 = pressed
//   db_level_o : debounced level (registered)
//   scen_o     : one-cycle pulse on accepted press (registered)
//   mcen_o     : one-cycle pulse on press and on every repeat (registered)
// -----------------------------------------------------------------------------
module button_channel_fsm
  import button_pkg::*;
#(
  parameter int DB_LIMIT   = DEF_DB_LIMIT,
  parameter int RPT_EN     = DEF_RPT_EN,
  parameter int RPT_DELAY  = DEF_RPT_DELAY,
  parameter int RPT_PERIOD = DEF_RPT_PERIOD,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic sys_clk,
  input  logic Reset,
  input  logic pb_i,
  output logic db_level_o,
  output logic scen_o,
  output logic mcen_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_LIMIT - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(RPT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(RPT_PERIOD - 1);
  localparam logic             RPT_ON    = (RPT_EN != 0);

  logic [1:0]       sync_q;
  logic             s_s;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_d, scen_d, mcen_d;

  // The FSM only ever looks at the second synchroniser stage.
  assign s_s = sync_q[1];

  // State, counter, synchroniser and registered outputs.
  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) begin
      sync_q     <= 2'b00;
      state_q    <= IDLE;
      cnt_q      <= CNT_ZERO;
      db_level_o <= 1'b0;
      scen_o     <= 1'b0;
      mcen_o     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], pb_i};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      db_level_o <= db_d;
      scen_o     <= scen_d;
      mcen_o     <= mcen_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (s_s) begin
          state_d = DB_PRESS;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      DB_PRESS: begin
        if (!s_s) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!s_s) begin
          state_d = DB_RELEASE;
          cnt_d   = CNT_ZERO;
        end else if (RPT_ON && (cnt_q == DLY_LAST)) begin
          state_d = RPT;
          cnt_d   = CNT_ZERO;
        end else if (RPT_ON) begin
          cnt_d   = cnt_q + CNT_ONE;
        end else begin
          cnt_d   = cnt_q;   // no repeat: timer parked
        end
      end
      RPT: begin
        if (!s_s) begin
          state_d = DB_RELEASE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == PER_LAST) begin
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      DB_RELEASE: begin
        // A bounce back high returns to HELD and restarts the repeat delay.
        if (s_s) begin
          state_d = HELD;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output decode; pulses fire on the transition condition itself.
  always_comb begin
    scen_d = 1'b0;
    mcen_d = 1'b0;
    case (state_q)
      DB_PRESS: begin
        scen_d = s_s && (cnt_q == DB_LAST);
        mcen_d = s_s && (cnt_q == DB_LAST);
      end
      HELD:    mcen_d = RPT_ON && s_s && (cnt_q == DLY_LAST);
      RPT:     mcen_d = s_s && (cnt_q == PER_LAST);
      default: begin
        scen_d = 1'b0;
        mcen_d = 1'b0;
      end
    endcase
    // Level is high from accepted press until the release is accepted.
    db_d = (state_d == HELD) || (state_d == RPT) || (state_d == DB_RELEASE);
  end

endmodule

// File: rtl/button_input_unit.sv
// -----------------------------------------------------------------------------
// button_input_unit
// Multi-channel pushbutton front end: one button_channel_fsm per channel plus
// a lowest-index-first merge of all press/repeat events into one stream.
//   sys_clk    : system clock (100 MHz)
//   Reset      : asynchronous, active-high
//   pb_in_i    : raw button levels, 1 = pressed
//   db_level_o : debounced levels
//   scen_o     : press pulses
//   mcen_o     : press + repeat pulses
//   evt_if     : merged event stream (master side)
// -----------------------------------------------------------------------------
module button_input_unit
  import button_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int DB_LIMIT   = DEF_DB_LIMIT,
  parameter int RPT_EN     = DEF_RPT_EN,
  parameter int RPT_DELAY  = DEF_RPT_DELAY,
  parameter int RPT_PERIOD = DEF_RPT_PERIOD,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             sys_clk,
  input  logic             Reset,
  input  logic [N_CH-1:0]  pb_in_i,
  output logic [N_CH-1:0]  db_level_o,
  output logic [N_CH-1:0]  scen_o,
  output logic [N_CH-1:0]  mcen_o,
  button_input_unit_if.master evt_if
);

  localparam int CODE_W = code_width(N_CH);

  logic [N_CH-1:0]   pend_q, pend_d;
  logic [N_CH-1:0]   prpt_q, prpt_d;
  logic [N_CH-1:0]   ovf_q, ovf_d;
  logic [N_CH-1:0]   unload_s, lost_s, take_s;
  logic              load_s, any_s;
  logic [CODE_W-1:0] sel_s;
  logic              valid_q, valid_d;
  logic              rep_q, rep_d;
  logic [CODE_W-1:0] code_q, code_d;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    button_channel_fsm #(
      .DB_LIMIT   (DB_LIMIT),
      .RPT_EN     (RPT_EN),
      .RPT_DELAY  (RPT_DELAY),
      .RPT_PERIOD (RPT_PERIOD),
      .CNT_W      (CNT_W)
    ) u_ch (
      .sys_clk    (sys_clk),
      .Reset      (Reset),
      .pb_i       (pb_in_i[g]),
      .db_level_o (db_level_o[g]),
      .scen_o     (scen_o[g]),
      .mcen_o     (mcen_o[g])
    );
  end

  // Lowest-index pending channel and which pending bit unloads this cycle.
  always_comb begin
    any_s    = 1'b0;
    sel_s    = {CODE_W{1'b0}};
    unload_s = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      sel_s = (!any_s && pend_q[i]) ? CODE_W'(i) : sel_s;
      any_s = any_s | pend_q[i];
    end
    load_s = !valid_q || evt_if.evt_ready;
    for (int i = 0; i < N_CH; i++) begin
      unload_s[i] = load_s && any_s && (sel_s == CODE_W'(i));
    end
  end

  // Pending bookkeeping: an event on a still-occupied slot is lost, unless
  // that slot is being unloaded in the same cycle.
  always_comb begin
    lost_s = {N_CH{1'b0}};
    take_s = {N_CH{1'b0}};
    pend_d = {N_CH{1'b0}};
    prpt_d = {N_CH{1'b0}};
    ovf_d  = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      lost_s[i] = mcen_o[i] & pend_q[i] & ~unload_s[i];
      take_s[i] = mcen_o[i] & ~lost_s[i];
      pend_d[i] = take_s[i] | (pend_q[i] & ~unload_s[i]);
      prpt_d[i] = take_s[i] ? ~scen_o[i] : prpt_q[i];
      ovf_d[i]  = ovf_q[i] | lost_s[i];
    end
  end

  // Event output register; holds while the consumer stalls.
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    rep_d   = rep_q;
    if (load_s) begin
      valid_d = any_s;
      if (any_s) begin
        code_d = sel_s;
        rep_d  = prpt_q[sel_s];
      end else begin
        code_d = code_q;
        rep_d  = rep_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Merge-path state registers.
  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) begin
      pend_q  <= {N_CH{1'b0}};
      prpt_q  <= {N_CH{1'b0}};
      ovf_q   <= {N_CH{1'b0}};
      valid_q <= 1'b0;
      rep_q   <= 1'b0;
      code_q  <= {CODE_W{1'b0}};
    end else begin
      pend_q  <= pend_d;
      prpt_q  <= prpt_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      rep_q   <= rep_d;
      code_q  <= code_d;
    end
  end

  assign evt_if.evt_valid    = valid_q;
  assign evt_if.evt_code     = code_q;
  assign evt_if.evt_repeat   = rep_q;
  assign evt_if.evt_overflow = ovf_q;

endmodule

// File: tb/tb_button_input_unit.sv
// -----------------------------------------------------------------------------
// tb_button_input_unit
// Directed bench for button_input_unit (N_CH=5, DB_LIMIT=4, RPT_DELAY=10,
// RPT_PERIOD=3). Stimulus pushes expected events into a scoreboard queue;
// a monitor pops and compares on every handshake and checks stall stability.
// "Edge k" below counts rising edges after the edge that pb was driven on.
// -----------------------------------------------------------------------------
module tb_button_input_unit;
  import button_pkg::*;

  localparam int N_CH   = 5;
  localparam int CODE_W = 3;

  logic             sys_clk;
  logic             Reset;
  logic [N_CH-1:0]  pb;
  logic [N_CH-1:0]  db, scen, mcen;
  logic             ready;

  int total = 0;
  int bad   = 0;
  logic [3:0] sb_q[$];     // {code, repeat}
  logic [40:0] mexp;

  button_input_unit_if #(.N_CH(N_CH), .CODE_W(CODE_W)) evt_if ();
  assign evt_if.evt_ready = ready;

  button_input_unit #(
    .N_CH(N_CH), .DB_LIMIT(4), .RPT_EN(1), .RPT_DELAY(10), .RPT_PERIOD(3), .CNT_W(8)
  ) dut (
    .sys_clk    (sys_clk),
    .Reset      (Reset),
    .pb_in_i    (pb),
    .db_level_o (db),
    .scen_o     (scen),
    .mcen_o     (mcen),
    .evt_if     (evt_if)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(posedge sys_clk);
    chk("drain", 32'(sb_q.size()), 32'd0);
    repeat (12) @(posedge sys_clk);
  endtask

  // Scoreboard monitor: handshake compare and stall stability.
  initial begin : monitor
    logic       held;
    logic [3:0] hv;
    logic [3:0] e;
    held = 1'b0;
    hv   = 4'd0;
    forever begin
      @(negedge sys_clk);
      if (Reset) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("evt_hold_valid", 32'(evt_if.evt_valid), 32'd1);
          chk("evt_hold_stable", 32'({evt_if.evt_code, evt_if.evt_repeat}), 32'(hv));
        end
        if (evt_if.evt_valid && ready) begin
          held = 1'b0;
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL evt_unexpected: got code=%0d rpt=%0d expected none at %0t",
                     evt_if.evt_code, evt_if.evt_repeat, $time);
          end else begin
            e = sb_q.pop_front();
            chk("evt", 32'({evt_if.evt_code, evt_if.evt_repeat}), 32'(e));
          end
        end else if (evt_if.evt_valid) begin
          held = 1'b1;
          hv   = {evt_if.evt_code, evt_if.evt_repeat};
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    pb    = 5'b00000;
    ready = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_db",    32'(db),   32'd0);
    chk("rst_scen",  32'(scen), 32'd0);
    chk("rst_mcen",  32'(mcen), 32'd0);
    chk("rst_valid", 32'(evt_if.evt_valid), 32'd0);
    chk("rst_ovf",   32'(evt_if.evt_overflow), 32'd0);
    chk("rst_code",  32'({evt_if.evt_code, evt_if.evt_repeat}), 32'd0);
    @(posedge sys_clk); #1 Reset = 1'b0;
    repeat (4) @(posedge sys_clk);

    // T1: 3-cycle glitch on ch0 is rejected.
    @(posedge sys_clk); #1 pb[0] = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge sys_clk); #1;
      if (k == 3) pb[0] = 1'b0;
      @(negedge sys_clk);
      chk("t1_scen",  32'(scen), 32'd0);
      chk("t1_db",    32'(db),   32'd0);
      chk("t1_valid", 32'(evt_if.evt_valid), 32'd0);
    end

    // T2: ch2 held, press at 7, repeats at 17 then every 3.
    ready = 1'b1;
    mexp = '0;
    mexp[7] = 1'b1; mexp[17] = 1'b1; mexp[20] = 1'b1;
    mexp[23] = 1'b1; mexp[26] = 1'b1; mexp[29] = 1'b1;
    sb_q.push_back({3'd2, 1'b0});
    for (int i = 0; i < 5; i++) sb_q.push_back({3'd2, 1'b1});
    @(posedge sys_clk); #1 pb[2] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge sys_clk); #1;
      if (k == 28) pb[2] = 1'b0;
      @(negedge sys_clk);
      chk("t2_scen", 32'(scen[2]), 32'(k == 7));
      chk("t2_mcen", 32'(mcen[2]), 32'(mexp[k]));
      chk("t2_db",   32'(db[2]),   32'(k >= 7 && k <= 34));
    end
    drain();

    // T3: ch1 release with a 2-cycle bounce inside the release debounce.
    sb_q.push_back({3'd1, 1'b0});
    @(posedge sys_clk); #1 pb[1] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge sys_clk); #1;
      if (k == 12) pb[1] = 1'b0;
      if (k == 14) pb[1] = 1'b1;
      if (k == 16) pb[1] = 1'b0;
      @(negedge sys_clk);
      chk("t3_db",   32'(db[1]),   32'(k >= 7 && k <= 22));
      chk("t3_scen", 32'(scen[1]), 32'(k == 7));
      chk("t3_mcen", 32'(mcen[1]), 32'(k == 7));
    end
    drain();

    // T4: ch3 and ch4 together, consumer stalled; ch3 first, then ch4.
    ready = 1'b0;
    sb_q.push_back({3'd3, 1'b0});
    sb_q.push_back({3'd4, 1'b0});
    @(posedge sys_clk); #1 pb[4:3] = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      @(posedge sys_clk); #1;
      if (k == 12) pb[4:3] = 2'b00;
      if (k == 13) ready = 1'b1;
      @(negedge sys_clk);
      chk("t4_scen", 32'(scen[4:3]), (k == 7) ? 32'd3 : 32'd0);
      if (k >= 9 && k <= 13) chk("t4_code", 32'(evt_if.evt_code), 32'd3);
      if (k == 20) chk("t4_idle", 32'(evt_if.evt_valid), 32'd0);
    end
    drain();
    chk("t4_ovf", 32'(evt_if.evt_overflow), 32'd0);

    // T5: ch0 held with consumer stalled; second repeat overflows.
    ready = 1'b0;
    sb_q.push_back({3'd0, 1'b0});
    sb_q.push_back({3'd0, 1'b1});
    @(posedge sys_clk); #1 pb[0] = 1'b1;
    for (int k = 1; k <= 42; k++) begin
      @(posedge sys_clk); #1;
      if (k == 38) pb[0] = 1'b0;
      if (k == 42) ready = 1'b1;
      @(negedge sys_clk);
      chk("t5_ovf", 32'(evt_if.evt_overflow), (k >= 21) ? 32'd1 : 32'd0);
    end
    drain();
    chk("t5_ovf_sticky", 32'(evt_if.evt_overflow), 32'd1);

    // T6: Reset while ch2 repeats and an event is stalled.
    ready = 1'b0;
    sb_q.push_back({3'd2, 1'b0});
    @(posedge sys_clk); #1 pb[2] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge sys_clk); #1;
      @(negedge sys_clk);
      if (k == 20) begin
        chk("t6_pre_valid", 32'(evt_if.evt_valid), 32'd1);
        chk("t6_pre_db",    32'(db[2]), 32'd1);
      end
    end
    #2 Reset = 1'b1;
    #1;
    sb_q.delete();
    chk("t6_rst_db",    32'(db),   32'd0);
    chk("t6_rst_scen",  32'(scen), 32'd0);
    chk("t6_rst_mcen",  32'(mcen), 32'd0);
    chk("t6_rst_valid", 32'(evt_if.evt_valid), 32'd0);
    chk("t6_rst_ovf",   32'(evt_if.evt_overflow), 32'd0);
    repeat (2) @(posedge sys_clk);
    #1 Reset = 1'b0;
    ready = 1'b1;
    sb_q.push_back({3'd2, 1'b0});
    for (int k = 1; k <= 9; k++) begin
      @(posedge sys_clk); #1;
      if (k == 9) pb[2] = 1'b0;
      @(negedge sys_clk);
      chk("t6_scen", 32'(scen[2]), 32'(k == 7));
    end
    drain();
    chk("t6_ovf", 32'(evt_if.evt_overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
